// File: rtl/data_memory_ctrl_pkg.sv
// Shared types for the data memory controller: FSM states, RW encodings, parity helper.
// The parity helper is used only when DATA_MEMORY_PARITY_EN is defined.
package data_mem_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  // Callers zero-extend; the extra zeros do not change the XOR reduction.
  function automatic logic even_parity(input logic [63:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/data_memory_ctrl_if.sv
// Request/ready bus between the datapath and the data memory controller.
// Err_Inject / Parity_Err exist only when DATA_MEMORY_PARITY_EN is defined.
interface data_memory_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) ();
  logic              Req;
  logic              RW;
  logic [ADDR_W-1:0] Addr_Bus;
  logic [DATA_W-1:0] DataIn;
  logic              Ready;
  logic [DATA_W-1:0] DataOut;
  logic              Valid;
  logic              Addr_Err;
`ifdef DATA_MEMORY_PARITY_EN
  logic              Err_Inject;
  logic              Parity_Err;
`endif

  modport master (
    output Req, RW, Addr_Bus, DataIn,
`ifdef DATA_MEMORY_PARITY_EN
    output Err_Inject,
    input  Parity_Err,
`endif
    input  Ready, DataOut, Valid, Addr_Err
  );

  modport slave (
    input  Req, RW, Addr_Bus, DataIn,
`ifdef DATA_MEMORY_PARITY_EN
    input  Err_Inject,
    output Parity_Err,
`endif
    output Ready, DataOut, Valid, Addr_Err
  );
endinterface

// File: rtl/data_memory_ctrl_array.sv
// Plain single-port synchronous RAM; rdata only changes on a read enable so it
// holds the last read word between reads.
module data_mem_array #(
  parameter int WORD_W = 8,
  parameter int DEPTH  = 256,
  parameter int IDX_W  = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [IDX_W-1:0]  addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/data_memory_ctrl.sv
// Data memory controller: post-reset clear sweep, request/ready handshake,
// range check, registered read with Valid/Addr_Err strobes. Optional DATA_MEMORY_PARITY_EN.
module data_memory_ctrl
  import data_mem_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input logic              clk,
  input logic              rst,
  data_memory_ctrl_if.slave bus
);

`ifdef DATA_MEMORY_PARITY_EN
  localparam int WORD_W = DATA_W + 1;
`else
  localparam int WORD_W = DATA_W;
`endif
  localparam int                IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST   = ADDR_W'(DEPTH - 1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] cnt;
  logic              ready;
  logic              accept_p0, oor_p0, rd_p0;
  logic              ram_we, ram_re;
  logic [IDX_W-1:0]  ram_addr;
  logic [WORD_W-1:0] ram_wdata, ram_rdata;
  logic              vld_p1, err_p1, zero_p1;

  // Full-width compare so upper address bits can only flag an error, never alias.
  assign oor_p0    = {1'b0, bus.Addr_Bus} >= DEPTH_L;
  assign accept_p0 = bus.Req && ready;
  assign rd_p0     = accept_p0 && (bus.RW == RW_READ);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_CLEAR;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst)                    cnt <= '0;
    else if (state == ST_CLEAR) cnt <= cnt + ADDR_W'(1);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_CLEAR: if (cnt == LAST) state_nxt = ST_IDLE;
      ST_IDLE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_CLEAR;
    endcase
  end

  always_comb begin
    ready     = 1'b0;
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    ram_addr  = bus.Addr_Bus[IDX_W-1:0];
    ram_wdata = '0;
    case (state)
      ST_CLEAR: begin
        ram_we   = 1'b1;
        ram_addr = cnt[IDX_W-1:0];
      end
      ST_IDLE: begin
        ready  = 1'b1;
        ram_we = accept_p0 && (bus.RW == RW_WRITE) && !oor_p0;
        ram_re = rd_p0 && !oor_p0;
`ifdef DATA_MEMORY_PARITY_EN
        ram_wdata = {even_parity(64'(bus.DataIn)) ^ bus.Err_Inject, bus.DataIn};
`else
        ram_wdata = bus.DataIn;
`endif
      end
      default: ;
    endcase
  end

  data_mem_array #(
    .WORD_W (WORD_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk   (clk),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // p0 -> p1: strobes; zero_p1 masks DataOut after reset or an out-of-range read.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      err_p1  <= 1'b0;
      zero_p1 <= 1'b1;
    end else begin
      vld_p1 <= rd_p0;
      err_p1 <= accept_p0 && oor_p0;
      if (rd_p0) zero_p1 <= oor_p0;
    end
  end

  assign bus.Ready    = ready;
  assign bus.Valid    = vld_p1;
  assign bus.Addr_Err = err_p1;
  assign bus.DataOut  = zero_p1 ? '0 : ram_rdata[DATA_W-1:0];
`ifdef DATA_MEMORY_PARITY_EN
  assign bus.Parity_Err = vld_p1 && !zero_p1 && even_parity(64'(ram_rdata));
`endif

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed bench for data_memory_ctrl: default-depth instance plus a DEPTH=200 instance.
// Parity scenario is compiled in when DATA_MEMORY_PARITY_EN is defined.
module tb_data_memory_ctrl;

  logic clk = 1'b0;
  logic rst_a, rst_b;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  data_memory_ctrl_if #(.DATA_W(8), .ADDR_W(8)) bus_a ();
  data_memory_ctrl_if #(.DATA_W(8), .ADDR_W(8)) bus_b ();

  data_memory_ctrl #(.DATA_W(8), .ADDR_W(8), .DEPTH(256)) u_dut_a (
    .clk (clk), .rst (rst_a), .bus (bus_a)
  );
  data_memory_ctrl #(.DATA_W(8), .ADDR_W(8), .DEPTH(200)) u_dut_b (
    .clk (clk), .rst (rst_b), .bus (bus_b)
  );

  task automatic idle_a();
    bus_a.Req = 1'b0; bus_a.RW = 1'b0; bus_a.Addr_Bus = '0; bus_a.DataIn = '0;
`ifdef DATA_MEMORY_PARITY_EN
    bus_a.Err_Inject = 1'b0;
`endif
  endtask

  task automatic idle_b();
    bus_b.Req = 1'b0; bus_b.RW = 1'b0; bus_b.Addr_Bus = '0; bus_b.DataIn = '0;
`ifdef DATA_MEMORY_PARITY_EN
    bus_b.Err_Inject = 1'b0;
`endif
  endtask

  task automatic test_reset();
    int cnt_a, cnt_b, lim;
    logic [7:0] addrs [3];
    addrs[0] = 8'd0; addrs[1] = 8'd128; addrs[2] = 8'd255;
    idle_a(); idle_b();
    rst_a = 1'b1; rst_b = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_a = 1'b0; rst_b = 1'b0;
    n_chk++; if (bus_a.Ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", bus_a.Ready); end
    n_chk++; if (bus_a.Valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", bus_a.Valid); end
    n_chk++; if (bus_a.Addr_Err !== 1'b0) begin n_fail++; $display("FAIL reset_addr_err: got %b want 0", bus_a.Addr_Err); end
    n_chk++; if (bus_a.DataOut !== 8'h00) begin n_fail++; $display("FAIL reset_dataout: got %h want 00", bus_a.DataOut); end
    cnt_a = 0; cnt_b = 0; lim = 0;
    while ((bus_a.Ready !== 1'b1 || bus_b.Ready !== 1'b1) && lim < 600) begin
      if (bus_a.Ready !== 1'b1) cnt_a++;
      if (bus_b.Ready !== 1'b1) cnt_b++;
      lim++;
      @(negedge clk);
    end
    n_chk++; if (cnt_a != 256) begin n_fail++; $display("FAIL clear_len_256: got %0d cycles want 256", cnt_a); end
    n_chk++; if (cnt_b != 200) begin n_fail++; $display("FAIL clear_len_200: got %0d cycles want 200", cnt_b); end
    for (int i = 0; i < 3; i++) begin
      bus_a.Req = 1'b1; bus_a.RW = 1'b0; bus_a.Addr_Bus = addrs[i];
      @(negedge clk);
      idle_a();
      n_chk++; if (bus_a.Valid !== 1'b1) begin n_fail++; $display("FAIL clear_rd_valid[%0d]: got %b want 1", addrs[i], bus_a.Valid); end
      n_chk++; if (bus_a.DataOut !== 8'h00) begin n_fail++; $display("FAIL clear_rd_data[%0d]: got %h want 00", addrs[i], bus_a.DataOut); end
      @(negedge clk);
      n_chk++; if (bus_a.Valid !== 1'b0) begin n_fail++; $display("FAIL valid_one_cycle[%0d]: got %b want 0", addrs[i], bus_a.Valid); end
    end
  endtask

  task automatic test_write_read();
    bus_a.Req = 1'b1; bus_a.RW = 1'b1; bus_a.Addr_Bus = 8'h10; bus_a.DataIn = 8'hA5;
    @(negedge clk);
    n_chk++; if (bus_a.Valid !== 1'b0) begin n_fail++; $display("FAIL wr_no_valid: got %b want 0", bus_a.Valid); end
    bus_a.RW = 1'b0; bus_a.Addr_Bus = 8'h10; bus_a.DataIn = 8'h00;
    @(negedge clk);
    n_chk++; if (bus_a.Valid !== 1'b1) begin n_fail++; $display("FAIL raw_valid: got %b want 1", bus_a.Valid); end
    n_chk++; if (bus_a.DataOut !== 8'hA5) begin n_fail++; $display("FAIL raw_data: got %h want a5", bus_a.DataOut); end
    bus_a.RW = 1'b1; bus_a.Addr_Bus = 8'h11; bus_a.DataIn = 8'h3C;
    @(negedge clk);
    idle_a();
    n_chk++; if (bus_a.Valid !== 1'b0) begin n_fail++; $display("FAIL wr2_no_valid: got %b want 0", bus_a.Valid); end
    n_chk++; if (bus_a.DataOut !== 8'hA5) begin n_fail++; $display("FAIL hold_after_wr: got %h want a5", bus_a.DataOut); end
    @(negedge clk);
    n_chk++; if (bus_a.DataOut !== 8'hA5) begin n_fail++; $display("FAIL hold_idle: got %h want a5", bus_a.DataOut); end
    bus_a.Req = 1'b1; bus_a.RW = 1'b0; bus_a.Addr_Bus = 8'h11;
    @(negedge clk);
    idle_a();
    n_chk++; if (bus_a.DataOut !== 8'h3C) begin n_fail++; $display("FAIL rd_0x11: got %h want 3c", bus_a.DataOut); end
  endtask

  task automatic test_out_of_range();
    bus_b.Req = 1'b1; bus_b.RW = 1'b1; bus_b.Addr_Bus = 8'd199; bus_b.DataIn = 8'h5A;
    @(negedge clk);
    n_chk++; if (bus_b.Addr_Err !== 1'b0) begin n_fail++; $display("FAIL inrange_wr_err: got %b want 0", bus_b.Addr_Err); end
    bus_b.Addr_Bus = 8'd200; bus_b.DataIn = 8'hFF;
    @(negedge clk);
    n_chk++; if (bus_b.Addr_Err !== 1'b1) begin n_fail++; $display("FAIL oor_wr_err: got %b want 1", bus_b.Addr_Err); end
    n_chk++; if (bus_b.Valid !== 1'b0) begin n_fail++; $display("FAIL oor_wr_valid: got %b want 0", bus_b.Valid); end
    bus_b.RW = 1'b0; bus_b.Addr_Bus = 8'd199; bus_b.DataIn = 8'h00;
    @(negedge clk);
    n_chk++; if (bus_b.DataOut !== 8'h5A) begin n_fail++; $display("FAIL rd_199: got %h want 5a", bus_b.DataOut); end
    n_chk++; if (bus_b.Addr_Err !== 1'b0) begin n_fail++; $display("FAIL rd_199_err: got %b want 0", bus_b.Addr_Err); end
    bus_b.Addr_Bus = 8'd200;
    @(negedge clk);
    n_chk++; if (bus_b.Valid !== 1'b1 || bus_b.Addr_Err !== 1'b1) begin n_fail++; $display("FAIL oor_rd_strobes: got valid=%b err=%b want 1 1", bus_b.Valid, bus_b.Addr_Err); end
    n_chk++; if (bus_b.DataOut !== 8'h00) begin n_fail++; $display("FAIL oor_rd_data: got %h want 00", bus_b.DataOut); end
    bus_b.Addr_Bus = 8'd199;
    @(negedge clk);
    idle_b();
    n_chk++; if (bus_b.DataOut !== 8'h5A) begin n_fail++; $display("FAIL rd_199_again: got %h want 5a", bus_b.DataOut); end
    @(negedge clk);
    n_chk++; if (bus_b.Addr_Err !== 1'b0 || bus_b.Valid !== 1'b0) begin n_fail++; $display("FAIL oor_strobe_clear: got valid=%b err=%b want 0 0", bus_b.Valid, bus_b.Addr_Err); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_d [3];
    exp_d[0] = 8'h11; exp_d[1] = 8'h22; exp_d[2] = 8'h33;
    for (int i = 0; i < 3; i++) begin
      bus_a.Req = 1'b1; bus_a.RW = 1'b1; bus_a.Addr_Bus = 8'(i + 1); bus_a.DataIn = exp_d[i];
      @(negedge clk);
    end
    bus_a.RW = 1'b0; bus_a.DataIn = 8'h00; bus_a.Addr_Bus = 8'd1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      if (i < 2) bus_a.Addr_Bus = 8'(i + 2);
      else       idle_a();
      n_chk++; if (bus_a.Valid !== 1'b1 || bus_a.DataOut !== exp_d[i]) begin
        n_fail++; $display("FAIL b2b_rd[%0d]: got valid=%b data=%h want 1 %h", i + 1, bus_a.Valid, bus_a.DataOut, exp_d[i]);
      end
      @(negedge clk);
    end
    n_chk++; if (bus_a.Valid !== 1'b0) begin n_fail++; $display("FAIL b2b_end_valid: got %b want 0", bus_a.Valid); end
  endtask

`ifdef DATA_MEMORY_PARITY_EN
  task automatic test_parity();
    bus_a.Req = 1'b1; bus_a.RW = 1'b1; bus_a.Addr_Bus = 8'h20; bus_a.DataIn = 8'h07; bus_a.Err_Inject = 1'b1;
    @(negedge clk);
    bus_a.Err_Inject = 1'b0; bus_a.Addr_Bus = 8'h21;
    @(negedge clk);
    bus_a.RW = 1'b0; bus_a.Addr_Bus = 8'h20;
    @(negedge clk);
    bus_a.Addr_Bus = 8'h21;
    n_chk++; if (bus_a.Parity_Err !== 1'b1 || bus_a.Valid !== 1'b1 || bus_a.DataOut !== 8'h07) begin
      n_fail++; $display("FAIL parity_inject: got perr=%b valid=%b data=%h want 1 1 07", bus_a.Parity_Err, bus_a.Valid, bus_a.DataOut);
    end
    @(negedge clk);
    idle_a();
    n_chk++; if (bus_a.Parity_Err !== 1'b0 || bus_a.DataOut !== 8'h07) begin
      n_fail++; $display("FAIL parity_clean: got perr=%b data=%h want 0 07", bus_a.Parity_Err, bus_a.DataOut);
    end
  endtask
`endif

  task automatic test_reset_mid_sweep();
    int cnt, lim;
    bool_dummy: begin end
    // Read in flight when reset hits: its Valid must never appear.
    bus_a.Req = 1'b1; bus_a.RW = 1'b0; bus_a.Addr_Bus = 8'h10;
    rst_a = 1'b1;
    @(negedge clk);
    rst_a = 1'b0;
    n_chk++; if (bus_a.Valid !== 1'b0) begin n_fail++; $display("FAIL rst_cancel_valid: got %b want 0", bus_a.Valid); end
    for (int i = 0; i < 100; i++) @(negedge clk);
    rst_a = 1'b1;
    @(negedge clk);
    rst_a = 1'b0;
    cnt = 0; lim = 0;
    while (bus_a.Ready !== 1'b1 && lim < 600) begin
      if (bus_a.Valid !== 1'b0 || bus_a.Addr_Err !== 1'b0) begin
        n_chk++; n_fail++; $display("FAIL req_during_clear: got valid=%b err=%b want 0 0", bus_a.Valid, bus_a.Addr_Err);
      end
      cnt++; lim++;
      @(negedge clk);
    end
    n_chk++; if (cnt != 256) begin n_fail++; $display("FAIL mid_sweep_len: got %0d cycles want 256", cnt); end
    n_chk++; if (bus_a.Valid !== 1'b0) begin n_fail++; $display("FAIL no_queued_req: got %b want 0", bus_a.Valid); end
    // Held Req is now accepted; the earlier 0xA5 at 0x10 must have been swept.
    @(negedge clk);
    idle_a();
    n_chk++; if (bus_a.Valid !== 1'b1 || bus_a.DataOut !== 8'h00) begin
      n_fail++; $display("FAIL swept_0x10: got valid=%b data=%h want 1 00", bus_a.Valid, bus_a.DataOut);
    end
  endtask

  initial begin
    rst_a = 1'b0; rst_b = 1'b0;
    idle_a(); idle_b();
    test_reset();
    test_write_read();
    test_out_of_range();
    test_back_to_back();
`ifdef DATA_MEMORY_PARITY_EN
    test_parity();
`endif
    test_reset_mid_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
